// File: rtl/pagerank_pkg.sv
// Shared types and default widths for the PageRank scatter stage.
package pagerank_pkg;

    localparam int RANK_W_DEF = 64;
    localparam int ID_W_DEF   = 32;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        EMIT,
        NEXT,
        DONE
    } scatter_state_t;

endpackage

// File: rtl/pr_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, RANK_W cycles after start,
// then a one-cycle ready pulse with the quotient held until the next start.
module pr_seq_divider #(
    parameter int RANK_W = 64,
    parameter int ID_W   = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [RANK_W-1:0] dividend,
    input  logic [ID_W-1:0]   divisor,
    output logic              ready,
    output logic [RANK_W-1:0] quotient
);

    localparam int CNT_W = $clog2(RANK_W + 1);

    logic [ID_W-1:0]  rem;
    logic [ID_W-1:0]  div_q;
    logic [CNT_W-1:0] count;
    logic             running;
    logic [ID_W:0]    shifted;
    logic [ID_W-1:0]  diff;

    // The dividend is shifted out of the quotient register as quotient bits shift in.
    assign shifted = {rem, quotient[RANK_W-1]};
    assign diff    = shifted[ID_W-1:0] - div_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem      <= '0;
            div_q    <= '0;
            count    <= '0;
            running  <= 1'b0;
            ready    <= 1'b0;
            quotient <= '0;
        end else begin
            ready <= 1'b0;
            if (start) begin
                quotient <= dividend;
                rem      <= '0;
                div_q    <= divisor;
                count    <= CNT_W'(RANK_W);
                running  <= 1'b1;
            end else if (running) begin
                if (shifted >= {1'b0, div_q}) begin
                    rem      <= diff;
                    quotient <= {quotient[RANK_W-2:0], 1'b1};
                end else begin
                    rem      <= shifted[ID_W-1:0];
                    quotient <= {quotient[RANK_W-2:0], 1'b0};
                end
                count <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    running <= 1'b0;
                    ready   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pagerank_scatter_stream.sv
// Scatter stage: for each source, divides its old rank by its out-degree and streams
// one (dest_id, contribution) beat per child; zero-degree ranks accumulate into dangling_sum.
module pagerank_scatter_stream
    import pagerank_pkg::*;
#(
    parameter int NODES          = 4,
    parameter int MAX_OUT_DEGREE = 20,
    parameter int ID_W           = ID_W_DEF,
    parameter int RANK_W         = RANK_W_DEF
) (
    input  logic                                              clock,
    input  logic                                              reset_n,
    input  logic                                              start,
    input  logic [NODES-1:0][ID_W-1:0]                        source_id,
    input  logic [NODES-1:0][ID_W-1:0]                        out_degree,
    input  logic [NODES-1:0][MAX_OUT_DEGREE-1:0][ID_W-1:0]    dest_id,
    input  logic [NODES-1:0][RANK_W-1:0]                      rank_old,
    output logic                                              out_valid,
    input  logic                                              out_ready,
    output logic [ID_W-1:0]                                   out_node_id,
    output logic [RANK_W-1:0]                                 out_contrib,
    output logic                                              busy,
    output logic                                              done,
    output logic [RANK_W-1:0]                                 dangling_sum,
    output logic                                              degree_err,
    output scatter_state_t                                    debug_state,
    output logic [ID_W-1:0]                                   debug_source_id
);

    localparam int I_W    = $clog2(NODES) + 1;
    localparam int J_W    = $clog2(MAX_OUT_DEGREE) + 1;
    localparam int IDX_W  = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int JIDX_W = (MAX_OUT_DEGREE > 1) ? $clog2(MAX_OUT_DEGREE) : 1;
    localparam logic [ID_W-1:0] MAX_DEG = ID_W'(MAX_OUT_DEGREE);

    scatter_state_t state, state_next;

    logic [NODES-1:0][ID_W-1:0]                     src_q;
    logic [NODES-1:0][ID_W-1:0]                     deg_q;
    logic [NODES-1:0][MAX_OUT_DEGREE-1:0][ID_W-1:0] dst_q;
    logic [NODES-1:0][RANK_W-1:0]                   rank_q;
    logic [I_W-1:0]    i;
    logic [J_W-1:0]    j;
    logic              armed;
    logic              launched;
    logic              div_start;
    logic              div_ready;
    logic [RANK_W-1:0] div_quotient;
    logic [IDX_W-1:0]  i_idx;
    logic [JIDX_W-1:0] j_idx_next;
    logic [ID_W-1:0]   deg_cur;
    logic [ID_W-1:0]   n_emit;
    logic [RANK_W-1:0] rank_cur;
    logic              last_j;
    logic              more;

    assign i_idx      = i[IDX_W-1:0];
    assign j_idx_next = j[JIDX_W-1:0] + JIDX_W'(1);
    assign deg_cur    = deg_q[i_idx];
    assign rank_cur   = rank_q[i_idx];
    assign n_emit     = (deg_cur > MAX_DEG) ? MAX_DEG : deg_cur;
    assign last_j     = (ID_W'(j) + ID_W'(1)) == n_emit;
    assign more       = (int'(i) + 1) < NODES;

    assign busy            = (state != IDLE);
    assign done            = (state == DONE);
    assign debug_state     = state;
    assign debug_source_id = src_q[i_idx];

    pr_seq_divider #(
        .RANK_W (RANK_W),
        .ID_W   (ID_W)
    ) u_div (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (rank_cur),
        .divisor  (deg_cur),
        .ready    (div_ready),
        .quotient (div_quotient)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Output handshake: a beat transfers on a rising edge where out_valid and out_ready
    // are both high; once out_valid rises, it and its payload hold until that transfer.
    always_comb begin
        state_next = state;
        div_start  = 1'b0;
        unique case (state)
            IDLE: if (start && armed) state_next = DIV;
            DIV: begin
                if (deg_cur == '0) begin
                    state_next = NEXT;
                end else begin
                    div_start = !launched;
                    if (div_ready) state_next = EMIT;
                end
            end
            EMIT:    if (out_valid && out_ready && last_j) state_next = NEXT;
            NEXT:    state_next = more ? DIV : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            armed        <= 1'b0;
            src_q        <= '0;
            deg_q        <= '0;
            dst_q        <= '0;
            rank_q       <= '0;
            i            <= '0;
            j            <= '0;
            launched     <= 1'b0;
            dangling_sum <= '0;
            degree_err   <= 1'b0;
            out_valid    <= 1'b0;
            out_node_id  <= '0;
            out_contrib  <= '0;
        end else begin
            // Holds off start for the first cycle after reset release.
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (start && armed) begin
                        src_q        <= source_id;
                        deg_q        <= out_degree;
                        dst_q        <= dest_id;
                        rank_q       <= rank_old;
                        i            <= '0;
                        j            <= '0;
                        dangling_sum <= '0;
                        degree_err   <= 1'b0;
                    end
                end
                DIV: begin
                    if (deg_cur == '0) begin
                        dangling_sum <= dangling_sum + rank_cur;
                    end else begin
                        if (deg_cur > MAX_DEG) degree_err <= 1'b1;
                        if (!launched) launched <= 1'b1;
                        if (div_ready) begin
                            launched    <= 1'b0;
                            out_valid   <= 1'b1;
                            out_node_id <= dst_q[i_idx][0];
                            out_contrib <= div_quotient;
                            j           <= '0;
                        end
                    end
                end
                EMIT: begin
                    if (out_valid && out_ready) begin
                        if (last_j) begin
                            out_valid <= 1'b0;
                        end else begin
                            j           <= j + J_W'(1);
                            out_node_id <= dst_q[i_idx][j_idx_next];
                        end
                    end
                end
                NEXT: if (more) i <= i + I_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pagerank_scatter_stream.sv
// Directed bench for the scatter stage: two sources, four dest slots each, checked
// against hand-computed beat sequences, dangling sums and control pulses.
module tb_pagerank_scatter_stream;
    import pagerank_pkg::*;

    localparam int NODES  = 2;
    localparam int MAXD   = 4;
    localparam int ID_W   = 32;
    localparam int RANK_W = 64;

    logic clock = 1'b0;
    logic reset_n;
    logic start;
    logic out_ready;
    logic [NODES-1:0][ID_W-1:0]            source_id;
    logic [NODES-1:0][ID_W-1:0]            out_degree;
    logic [NODES-1:0][MAXD-1:0][ID_W-1:0]  dest_id;
    logic [NODES-1:0][RANK_W-1:0]          rank_old;
    logic              out_valid;
    logic [ID_W-1:0]   out_node_id;
    logic [RANK_W-1:0] out_contrib;
    logic              busy;
    logic              done;
    logic [RANK_W-1:0] dangling_sum;
    logic              degree_err;
    scatter_state_t    debug_state;
    logic [ID_W-1:0]   debug_source_id;

    int vectors     = 0;
    int miscompares = 0;

    logic [ID_W-1:0]   got_node[$];
    logic [RANK_W-1:0] got_contrib[$];
    int n_done;
    int stable_viol;
    bit timed_out;
    bit busy_after_done;
    bit busy_in_tail;

    pagerank_scatter_stream #(
        .NODES          (NODES),
        .MAX_OUT_DEGREE (MAXD),
        .ID_W           (ID_W),
        .RANK_W         (RANK_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .source_id       (source_id),
        .out_degree      (out_degree),
        .dest_id         (dest_id),
        .rank_old        (rank_old),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_node_id     (out_node_id),
        .out_contrib     (out_contrib),
        .busy            (busy),
        .done            (done),
        .dangling_sum    (dangling_sum),
        .degree_err      (degree_err),
        .debug_state     (debug_state),
        .debug_source_id (debug_source_id)
    );

    always #5 clock = ~clock;

    task automatic set_basic();
        source_id     = {32'd20, 32'd10};
        rank_old[0]   = 64'd100;
        rank_old[1]   = 64'd90;
        out_degree[0] = 32'd4;
        out_degree[1] = 32'd3;
        for (int k = 0; k < MAXD; k++) dest_id[0][k] = 32'(k + 1);
        for (int k = 0; k < 3; k++) dest_id[1][k] = 32'(k + 5);
        dest_id[1][3] = 32'd99;
    endtask

    task automatic scramble();
        source_id  = {32'd77, 32'd66};
        rank_old   = {64'd12345, 64'd999};
        out_degree = {32'd1, 32'd2};
        for (int n = 0; n < NODES; n++)
            for (int k = 0; k < MAXD; k++) dest_id[n][k] = 32'(200 + n * 10 + k);
    endtask

    task automatic pulse_start();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Runs one iteration at negedges: drives out_ready, logs accepted beats, watches
    // stall stability, and keeps observing 40 cycles past done.
    task automatic collect(input bit toggle_ready, input int start_mid, input bit start_at_done);
        bit prev_stall;
        bit seen_done;
        int tail;
        logic [ID_W-1:0]   prev_node;
        logic [RANK_W-1:0] prev_contrib;
        got_node.delete();
        got_contrib.delete();
        n_done = 0; stable_viol = 0; timed_out = 1'b1;
        busy_after_done = 1'b1; busy_in_tail = 1'b0;
        prev_stall = 1'b0; seen_done = 1'b0; tail = 0;
        prev_node = '0; prev_contrib = '0;
        for (int c = 0; c < 800; c++) begin
            out_ready = toggle_ready ? ((c % 2) == 0) : 1'b1;
            start     = (c == start_mid) || (start_at_done && done);
            if (prev_stall && (!out_valid || out_node_id !== prev_node || out_contrib !== prev_contrib))
                stable_viol++;
            if (out_valid && out_ready) begin
                got_node.push_back(out_node_id);
                got_contrib.push_back(out_contrib);
            end
            prev_stall   = out_valid && !out_ready;
            prev_node    = out_node_id;
            prev_contrib = out_contrib;
            if (seen_done) begin
                tail++;
                if (tail == 1) busy_after_done = busy;
                if (busy) busy_in_tail = 1'b1;
            end
            if (done) begin
                n_done++;
                seen_done = 1'b1;
                timed_out = 1'b0;
            end
            if (tail >= 40) break;
            @(negedge clock);
        end
        start     = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start = 1'b0; out_ready = 1'b1;
        set_basic();
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (degree_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", degree_err); end
        vectors++; if (dangling_sum !== '0) begin miscompares++; $display("FAIL reset_dangling: got %0d want 0", dangling_sum); end
        vectors++; if (out_node_id !== '0 || out_contrib !== '0) begin miscompares++; $display("FAIL reset_payload: got %0d/%0d want 0/0", out_node_id, out_contrib); end
        vectors++; if (debug_state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", debug_state, IDLE); end
        // start held across release must be ignored in the first cycle after it
        start = 1'b1; reset_n = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL release_start: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int en[7] = '{1, 2, 3, 4, 5, 6, 7};
        int ec[7] = '{25, 25, 25, 25, 30, 30, 30};
        set_basic();
        pulse_start();
        vectors++; if (debug_source_id !== 32'd10) begin miscompares++; $display("FAIL basic_src: got %0d want 10", debug_source_id); end
        scramble();
        collect(1'b0, -1, 1'b0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout: got no done want done"); end
        vectors++; if (got_node.size() != 7) begin miscompares++; $display("FAIL basic_count: got %0d want 7", got_node.size()); end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (k >= got_node.size() || got_node[k] !== ID_W'(en[k]) || got_contrib[k] !== RANK_W'(ec[k])) begin
                miscompares++;
                $display("FAIL basic_beat%0d: got (%0d,%0d) want (%0d,%0d)", k,
                         (k < got_node.size()) ? got_node[k] : '0, (k < got_contrib.size()) ? got_contrib[k] : '0, en[k], ec[k]);
            end
        end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL basic_done: got %0d want 1", n_done); end
        vectors++; if (busy_after_done !== 1'b0) begin miscompares++; $display("FAIL basic_busy_after: got %b want 0", busy_after_done); end
        vectors++; if (dangling_sum !== '0) begin miscompares++; $display("FAIL basic_dangling: got %0d want 0", dangling_sum); end
        vectors++; if (degree_err !== 1'b0) begin miscompares++; $display("FAIL basic_err: got %b want 0", degree_err); end
    endtask

    task automatic test_stall();
        int en[7] = '{1, 2, 3, 4, 5, 6, 7};
        int ec[7] = '{25, 25, 25, 25, 30, 30, 30};
        set_basic();
        pulse_start();
        collect(1'b1, -1, 1'b0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL stall_timeout: got no done want done"); end
        vectors++; if (got_node.size() != 7) begin miscompares++; $display("FAIL stall_count: got %0d want 7", got_node.size()); end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (k >= got_node.size() || got_node[k] !== ID_W'(en[k]) || got_contrib[k] !== RANK_W'(ec[k])) begin
                miscompares++;
                $display("FAIL stall_beat%0d: got (%0d,%0d) want (%0d,%0d)", k,
                         (k < got_node.size()) ? got_node[k] : '0, (k < got_contrib.size()) ? got_contrib[k] : '0, en[k], ec[k]);
            end
        end
        vectors++; if (stable_viol != 0) begin miscompares++; $display("FAIL stall_stable: got %0d changes want 0", stable_viol); end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL stall_done: got %0d want 1", n_done); end
    endtask

    task automatic test_dangling();
        rank_old      = {64'd7, 64'd500};
        out_degree    = {32'd2, 32'd0};
        dest_id[1][0] = 32'd9;
        dest_id[1][1] = 32'd8;
        pulse_start();
        collect(1'b0, -1, 1'b0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL dangling_timeout: got no done want done"); end
        vectors++;
        if (got_node.size() != 2 || got_node[0] !== 32'd9 || got_contrib[0] !== 64'd3 ||
            got_node[1] !== 32'd8 || got_contrib[1] !== 64'd3) begin
            miscompares++;
            $display("FAIL dangling_beats: got %0d beats first (%0d,%0d) want 2 beats (9,3),(8,3)", got_node.size(),
                     (got_node.size() > 0) ? got_node[0] : '0, (got_contrib.size() > 0) ? got_contrib[0] : '0);
        end
        vectors++; if (dangling_sum !== 64'd500) begin miscompares++; $display("FAIL dangling_sum: got %0d want 500", dangling_sum); end
    endtask

    task automatic test_degree_err();
        rank_old   = {64'd0, 64'd60};
        out_degree = {32'd0, 32'd6};
        for (int k = 0; k < MAXD; k++) dest_id[0][k] = 32'(11 + k);
        pulse_start();
        collect(1'b0, -1, 1'b0);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL err_timeout: got no done want done"); end
        vectors++; if (got_node.size() != 4) begin miscompares++; $display("FAIL err_count: got %0d want 4", got_node.size()); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (k >= got_node.size() || got_node[k] !== 32'(11 + k) || got_contrib[k] !== 64'd10) begin
                miscompares++;
                $display("FAIL err_beat%0d: got (%0d,%0d) want (%0d,10)", k,
                         (k < got_node.size()) ? got_node[k] : '0, (k < got_contrib.size()) ? got_contrib[k] : '0, 11 + k);
            end
        end
        vectors++; if (degree_err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b want 1", degree_err); end
        set_basic();
        pulse_start();
        vectors++; if (degree_err !== 1'b0) begin miscompares++; $display("FAIL err_clear: got %b want 0", degree_err); end
        collect(1'b0, -1, 1'b0);
        vectors++; if (timed_out || degree_err !== 1'b0) begin miscompares++; $display("FAIL err_clean_run: err %b timeout %b want 0 0", degree_err, timed_out); end
    endtask

    task automatic test_reset_mid();
        int beats;
        bit reached;
        int stray;
        int en[7] = '{1, 2, 3, 4, 5, 6, 7};
        int ec[7] = '{25, 25, 25, 25, 30, 30, 30};
        set_basic();
        pulse_start();
        beats = 0; reached = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (out_valid && beats == 2) begin reached = 1'b1; break; end
            if (out_valid) beats++;
            @(negedge clock);
        end
        vectors++; if (!reached) begin miscompares++; $display("FAIL mid_reach: got %0d beats want third beat presented", beats); end
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL mid_abort: valid %b busy %b done %b want 0 0 0", out_valid, busy, done); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clock);
            if (out_valid || done || busy) stray++;
        end
        vectors++; if (stray != 0) begin miscompares++; $display("FAIL mid_quiet: got %0d active cycles want 0", stray); end
        pulse_start();
        collect(1'b0, -1, 1'b0);
        vectors++; if (timed_out || n_done != 1 || got_node.size() != 7) begin miscompares++; $display("FAIL mid_rerun: done %0d beats %0d want 1 7", n_done, got_node.size()); end
        for (int k = 0; k < 7; k++) begin
            vectors++;
            if (k >= got_node.size() || got_node[k] !== ID_W'(en[k]) || got_contrib[k] !== RANK_W'(ec[k])) begin
                miscompares++;
                $display("FAIL mid_beat%0d: got (%0d,%0d) want (%0d,%0d)", k,
                         (k < got_node.size()) ? got_node[k] : '0, (k < got_contrib.size()) ? got_contrib[k] : '0, en[k], ec[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        set_basic();
        pulse_start();
        collect(1'b0, 10, 1'b1);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL ign_timeout: got no done want done"); end
        vectors++; if (got_node.size() != 7) begin miscompares++; $display("FAIL ign_count: got %0d want 7", got_node.size()); end
        vectors++; if (n_done != 1) begin miscompares++; $display("FAIL ign_done: got %0d want 1", n_done); end
        vectors++; if (busy_in_tail) begin miscompares++; $display("FAIL ign_restart: busy after done got 1 want 0"); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_degree_err();
        test_dangling();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pagerank_scatter_stream.md
PAGERANK_SCATTER_STREAM -- requirements
Module: pagerank_scatter_stream

Interface
REQ-001 Parameter NODES, default 4: number of source vertices in the partition.
REQ-002 Parameter MAX_OUT_DEGREE, default 20: dest_id slots per source.
REQ-003 Parameter ID_W, default 32: vertex ID and degree width.
REQ-004 Parameter RANK_W, default 64: unsigned fixed-point rank width.
REQ-005 clock  in  1  rising-edge clock; reset reset_n, asynchronous, active-low.
REQ-006 start  in  1  one-cycle pulse; begins one scatter iteration; ignored while busy.
REQ-007 source_id  in  NODES x ID_W  vertex ID of each source slot.
REQ-008 out_degree  in  NODES x ID_W  out-degree of each source.
REQ-009 dest_id  in  NODES x MAX_OUT_DEGREE x ID_W  child IDs per source.
REQ-010 rank_old  in  NODES x RANK_W  previous-iteration rank per source.
REQ-011 out_valid  out  1  contribution present on out_node_id/out_contrib.
REQ-012 out_ready  in  1  downstream (gather) accepts when out_valid and out_ready are both high.
REQ-013 out_node_id  out  ID_W  destination vertex of the contribution.
REQ-014 out_contrib  out  RANK_W  rank_old[src] / out_degree[src].
REQ-015 busy  out  1  iteration in progress.
REQ-016 done  out  1  one-cycle pulse at iteration end.
REQ-017 dangling_sum  out  RANK_W  sum of rank_old for sources with out_degree 0; valid while done is high, held until the next start.
REQ-018 degree_err  out  1  sticky; set when any out_degree exceeds MAX_OUT_DEGREE; cleared on start.

Function
REQ-019 On an accepted start, all graph inputs shall be latched in the same cycle; input changes after that shall not affect the iteration.
REQ-020 FSM states: IDLE, DIV, EMIT, NEXT, DONE.
REQ-021 IDLE -> DIV on start; source index i=0; dangling_sum and degree_err are cleared.
REQ-022 DIV: if deg[i]==0, add rank[i] to dangling_sum (wrap mod 2^RANK_W), go to NEXT; otherwise run divider, go to EMIT when the quotient is ready.
REQ-023 Quotient = floor(rank[i]/deg[i]), computed once per source, RANK_W cycles, unsigned.
REQ-024 EMIT: for j = 0..min(deg[i],MAX_OUT_DEGREE)-1, present dest_id[i][j] and the quotient; j advances only on handshake; go to NEXT after the last handshake.
REQ-025 deg[i] > MAX_OUT_DEGREE: set degree_err; emit MAX_OUT_DEGREE entries; the divisor stays the true deg[i].
REQ-026 Once asserted, out_valid and its payload shall remain stable until the handshake completes.
REQ-027 NEXT: i++; go to DIV if i<NODES, otherwise go to DONE.
REQ-028 DONE: done=1 for one cycle; busy=0 next cycle; return to IDLE.
REQ-029 A start arriving in the DONE cycle shall be ignored.
REQ-030 Emission order: ascending i, then ascending j; no duplicates; no gaps.
REQ-031 Back-to-back handshakes shall give one contribution per cycle within a source.

Reset
REQ-032 Asynchronous assert of reset_n low: FSM enters IDLE; out_valid, busy, done, degree_err and all counters are 0; dangling_sum is 0; out_node_id and out_contrib are 0.
REQ-033 Reset mid-iteration shall abort the iteration; no done pulse is produced; no further out_valid is asserted until the next start.
REQ-034 Synchronous deassertion is the integrator's responsibility; the block shall take no start in the first cycle after release.

Structure
REQ-035 Shared package pagerank_pkg shall hold the FSM state enum (scatter_state_t) and the default RANK_W/ID_W constants.
REQ-036 Sub-module pr_seq_divider: restoring unsigned divider with start/ready, RANK_W-bit dividend, ID_W-bit divisor, RANK_W-bit quotient; never started with a zero divisor.
REQ-037 The i and j counters shall be local registers sized $clog2 of their bound plus 1.

Verification
REQ-038 NODES=2; ranks {100,90}; degrees {4,3}; dests {1,2,3,4},{5,6,7}; out_ready=1 -> 7 beats: (1,25),(2,25),(3,25),(4,25),(5,30),(6,30),(7,30); then done; dangling_sum=0.
REQ-039 Same stimulus, out_ready toggling 1-0 every cycle -> identical sequence; payload stable while stalled.
REQ-040 Degrees {0,2}; ranks {500,7}; dests for source 1 = {9,8} -> beats (9,3),(8,3); dangling_sum=500.
REQ-041 MAX_OUT_DEGREE=4; deg[0]=6; rank 60 -> 4 beats of contrib 10; degree_err=1; degree_err cleared by the next start.
REQ-042 Reset asserted during the 3rd beat of REQ-038 -> out_valid=0 immediately; no done; a new start reruns the full sequence.
REQ-043 start pulsed while busy, and again in the DONE cycle -> ignored; exactly one done per accepted start.
